// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline flow-control sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    // Advancing cycles spent in DRAIN before the pipeline is empty.
    localparam int DRAIN_CYCLES = 4;

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard inputs, pipeline-register control pins and status of the flow-control block.
interface pipe_ctrl_if #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
);
    localparam int RIDX_W = $clog2(NUM_REGS);

    logic [RIDX_W-1:0] id_rs1_i;
    logic [RIDX_W-1:0] id_rs2_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic [RIDX_W-1:0] ex_rd_i;
    logic              ex_mem_read_i;
    logic              ex_redirect_i;
    logic              mem_req_i;
    logic              mem_ready_i;
    logic              halt_req_i;
    logic              resume_req_i;

    logic              pc_stall_o;
    logic              if_id_stall_o;
    logic              id_ex_stall_o;
    logic              ex_mem_stall_o;
    logic              mem_wb_stall_o;
    logic              if_id_flush_o;
    logic              id_ex_flush_o;
    logic              ex_mem_flush_o;
    logic              mem_wb_flush_o;
    logic              halted_o;
    logic [CNT_W-1:0]  stall_cycles_o;
    logic [CNT_W-1:0]  flush_events_o;

    // Datapath / debug side.
    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
               ex_mem_read_i, ex_redirect_i, mem_req_i, mem_ready_i,
               halt_req_i, resume_req_i,
        input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               mem_wb_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
               mem_wb_flush_o, halted_o, stall_cycles_o, flush_events_o
    );

    // Controller side.
    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
               ex_mem_read_i, ex_redirect_i, mem_req_i, mem_ready_i,
               halt_req_i, resume_req_i,
        output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               mem_wb_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
               mem_wb_flush_o, halted_o, stall_cycles_o, flush_events_o
    );
endinterface

// File: rtl/pipe_perf_counter.sv
// Wrapping event counter used for the optional stall/flush statistics.
module pipe_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/pipeline_controller.sv
// Flow-control sequencer: hazard resolution plus debug halt/drain for the 5-stage core.
// Optional statistics counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);
    localparam int RIDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_DRAIN  = DRAIN;
    localparam logic [1:0] S_HALTED = HALTED;

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       halted_q;

    logic [RIDX_W-1:0] rs1, rs2, rd;
    logic        mem_wait, load_use, redirect;
    logic        pc_stall;
    stage_ctrl_t if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

    assign rs1      = bus.id_rs1_i;
    assign rs2      = bus.id_rs2_i;
    assign rd       = bus.ex_rd_i;
    assign redirect = bus.ex_redirect_i;
    assign mem_wait = bus.mem_req_i & ~bus.mem_ready_i;
    assign load_use = bus.ex_mem_read_i & (rd != '0) &
                      ((bus.id_rs1_used_i & (rs1 == rd)) |
                       (bus.id_rs2_used_i & (rs2 == rd)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_stall = 1'b0;
        if_id_c  = '0;
        id_ex_c  = '0;
        ex_mem_c = '0;
        mem_wb_c = '0;
        case (state_q)
            S_RUN: begin
                cnt_d = '0;
                if (mem_wait) begin
                    pc_stall       = 1'b1;
                    if_id_c.stall  = 1'b1;
                    id_ex_c.stall  = 1'b1;
                    ex_mem_c.stall = 1'b1;
                    mem_wb_c.flush = 1'b1;
                end else if (redirect) begin
                    if_id_c.flush  = 1'b1;
                    id_ex_c.flush  = 1'b1;
                end else if (load_use) begin
                    pc_stall       = 1'b1;
                    if_id_c.stall  = 1'b1;
                    id_ex_c.flush  = 1'b1;
                end
                if (bus.halt_req_i && !mem_wait && !redirect && !load_use) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // IF/ID is flushed every cycle, so its stall is never raised here.
                if_id_c.flush = 1'b1;
                pc_stall      = ~redirect | mem_wait;
                if (mem_wait) begin
                    id_ex_c.stall  = 1'b1;
                    ex_mem_c.stall = 1'b1;
                    mem_wb_c.flush = 1'b1;
                end else begin
                    id_ex_c.flush = redirect;
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == 2'(DRAIN_CYCLES - 1)) begin
                        state_d = S_HALTED;
                    end
                end
            end
            S_HALTED: begin
                pc_stall      = 1'b1;
                if_id_c.flush = 1'b1;
                if (bus.resume_req_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == S_HALTED);
        end
    end

    // Combinational pins are forced low while reset is held.
    assign bus.pc_stall_o     = rst_n & pc_stall;
    assign bus.if_id_stall_o  = rst_n & if_id_c.stall;
    assign bus.id_ex_stall_o  = rst_n & id_ex_c.stall;
    assign bus.ex_mem_stall_o = rst_n & ex_mem_c.stall;
    assign bus.mem_wb_stall_o = rst_n & mem_wb_c.stall;
    assign bus.if_id_flush_o  = rst_n & if_id_c.flush;
    assign bus.id_ex_flush_o  = rst_n & id_ex_c.flush;
    assign bus.ex_mem_flush_o = rst_n & ex_mem_c.flush;
    assign bus.mem_wb_flush_o = rst_n & mem_wb_c.flush;
    assign bus.halted_o       = halted_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (pc_stall),
        .count_o (bus.stall_cycles_o)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (redirect & ~mem_wait),
        .count_o (bus.flush_events_o)
    );
`else
    assign bus.stall_cycles_o = {CNT_W{1'b0}};
    assign bus.flush_events_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: hazards, halt/drain/resume and async reset.
module tb_pipeline_controller;
    import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.NUM_REGS(32), .CNT_W(32)) bus ();

    pipeline_controller #(.NUM_REGS(32), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic clear_inputs;
        bus.id_rs1_i = '0; bus.id_rs2_i = '0;
        bus.id_rs1_used_i = 1'b0; bus.id_rs2_used_i = 1'b0;
        bus.ex_rd_i = '0; bus.ex_mem_read_i = 1'b0; bus.ex_redirect_i = 1'b0;
        bus.mem_req_i = 1'b0; bus.mem_ready_i = 1'b0;
        bus.halt_req_i = 1'b0; bus.resume_req_i = 1'b0;
    endtask

    // Packs every control pin: {pc, ifid s/f, idex s/f, exmem s/f, memwb s/f}.
    function automatic logic [8:0] pins();
        return {bus.pc_stall_o,
                bus.if_id_stall_o, bus.if_id_flush_o,
                bus.id_ex_stall_o, bus.id_ex_flush_o,
                bus.ex_mem_stall_o, bus.ex_mem_flush_o,
                bus.mem_wb_stall_o, bus.mem_wb_flush_o};
    endfunction

    initial begin
        clear_inputs();
        // Reset state with a hazard on the inputs: outputs must stay low.
        bus.mem_req_i = 1'b1;
        #3;
        chk("reset_pins", 32'(pins()), 32'h0);
        chk("reset_halted", 32'(bus.halted_o), 32'd0);
        chk("reset_stallcnt", bus.stall_cycles_o, 32'd0);
        step();
        rst_n = 1'b1;
        clear_inputs();
        settle();
        chk("idle_pins", 32'(pins()), 32'h0);

        // Load-use on rs2: one cycle of pc/if_id stall and id_ex bubble.
        bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd5;
        bus.id_rs2_i = 5'd5; bus.id_rs2_used_i = 1'b1;
        settle();
        chk("loaduse_pins", 32'(pins()), 32'b1_10_01_00_00);
        step();
        bus.ex_mem_read_i = 1'b0;
        settle();
        chk("loaduse_after", 32'(pins()), 32'h0);
        chk("stallcnt_1", bus.stall_cycles_o, 32'(PERF * 1));

        // Load to x0 never stalls.
        bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd0;
        bus.id_rs1_i = 5'd0; bus.id_rs1_used_i = 1'b1; bus.id_rs2_i = 5'd0;
        settle();
        chk("loaduse_x0", 32'(pins()), 32'h0);

        // Redirect beats load-use.
        bus.ex_rd_i = 5'd5; bus.id_rs2_i = 5'd5;
        bus.ex_redirect_i = 1'b1;
        settle();
        chk("redir_lu_pins", 32'(pins()), 32'b0_01_01_00_00);
        chk("flushcnt_0", bus.flush_events_o, 32'd0);
        step();
        clear_inputs();
        settle();
        chk("flushcnt_1", bus.flush_events_o, 32'(PERF * 1));

        // Memory wait for 3 cycles with a redirect pending.
        bus.ex_redirect_i = 1'b1; bus.mem_req_i = 1'b1; bus.mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("memwait_freeze", 32'(pins()), 32'b1_10_10_10_01);
            step();
        end
        bus.mem_ready_i = 1'b1;
        settle();
        chk("memwait_redir", 32'(pins()), 32'b0_01_01_00_00);
        step();
        clear_inputs();
        settle();
        chk("stallcnt_4", bus.stall_cycles_o, 32'(PERF * 4));
        chk("flushcnt_2", bus.flush_events_o, 32'(PERF * 2));

        // Halt request during a memory wait does not leave RUN.
        bus.halt_req_i = 1'b1; bus.mem_req_i = 1'b1;
        settle();
        chk("halt_blocked", 32'(pins()), 32'b1_10_10_10_01);
        step();
        clear_inputs();
        settle();
        chk("still_run", 32'(pins()), 32'h0);

        // Halt from idle: halted_o rises on the 5th edge.
        bus.halt_req_i = 1'b1;
        step();
        bus.halt_req_i = 1'b0;
        settle();
        chk("drain_pins", 32'(pins()), 32'b1_01_00_00_00);
        for (int e = 2; e <= 5; e++) begin
            step();
            chk("halt_edge", 32'(bus.halted_o), 32'(e == 5));
        end
        settle();
        chk("halted_pins", 32'(pins()), 32'b1_01_00_00_00);
        bus.resume_req_i = 1'b1;
        step();
        bus.resume_req_i = 1'b0;
        chk("resume_halted", 32'(bus.halted_o), 32'd0);
        settle();
        chk("resume_pins", 32'(pins()), 32'h0);

        // Halt with one memory wait in DRAIN: rises on the 6th edge.
        bus.halt_req_i = 1'b1;
        step();
        bus.halt_req_i = 1'b0;
        step();
        bus.mem_req_i = 1'b1; bus.mem_ready_i = 1'b0;
        settle();
        chk("drain_memwait", 32'(pins()), 32'b1_01_10_10_01);
        step();
        bus.mem_req_i = 1'b0;
        for (int e = 4; e <= 6; e++) begin
            step();
            chk("halt_edge_w", 32'(bus.halted_o), 32'(e == 6));
        end
        bus.resume_req_i = 1'b1;
        step();
        bus.resume_req_i = 1'b0;
        chk("resume2", 32'(bus.halted_o), 32'd0);

        // Redirect during DRAIN lets the PC load its target.
        bus.halt_req_i = 1'b1;
        step();
        bus.halt_req_i = 1'b0;
        bus.ex_redirect_i = 1'b1;
        settle();
        chk("drain_redir", 32'(pins()), 32'b0_01_01_00_00);
        step();
        bus.ex_redirect_i = 1'b0;
        for (int e = 3; e <= 5; e++) begin
            step();
            chk("halt_edge_r", 32'(bus.halted_o), 32'(e == 5));
        end
        bus.resume_req_i = 1'b1;
        step();
        bus.resume_req_i = 1'b0;

        // Asynchronous reset in the middle of DRAIN.
        bus.halt_req_i = 1'b1;
        step();
        bus.halt_req_i = 1'b0;
        step();
        bus.mem_req_i = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pins", 32'(pins()), 32'h0);
        chk("async_rst_halt", 32'(bus.halted_o), 32'd0);
        step();
        rst_n = 1'b1;
        bus.mem_req_i = 1'b0;
        step();
        settle();
        chk("post_rst_pins", 32'(pins()), 32'h0);
        chk("post_rst_halted", 32'(bus.halted_o), 32'd0);
        chk("post_rst_stall", bus.stall_cycles_o, 32'd0);
        chk("post_rst_flush", bus.flush_events_o, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
